// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and helpers for the convolution address generator
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of window positions along one image axis.
    function automatic int out_dim(input int img, input int k, input int stride);
        return (img - k) / stride + 1;
    endfunction

endpackage

// File: rtl/conv_addr_gen_if.sv
// rtl/conv_addr_gen_if.sv - control and address bus between the generator and the PE datapath
interface conv_addr_gen_if #(
    parameter int ADDR_W = 14
);
    logic              start;
    logic              stall;
    logic [ADDR_W-1:0] base_addr_a;
    logic [ADDR_W-1:0] base_addr_b;
    logic [ADDR_W-1:0] result_addr;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic              addr_valid;
    logic              win_last;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              busy;
    logic              done;

    modport master (
        input  start, stall, base_addr_a, base_addr_b, result_addr,
        output addr_a, addr_b, addr_valid, win_last, wr_en, wr_addr, busy, done
    );

    modport slave (
        output start, stall, base_addr_a, base_addr_b, result_addr,
        input  addr_a, addr_b, addr_valid, win_last, wr_en, wr_addr, busy, done
    );
endinterface

// File: rtl/conv_win_counter.sv
// rtl/conv_win_counter.sv - cascaded kx/ky/c tap counters and ox/oy window counters
module conv_win_counter #(
    parameter int ADDR_W = 14,
    parameter int K      = 3,
    parameter int CH     = 1,
    parameter int OUT_W  = 46,
    parameter int OUT_H  = 46
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              tap_adv,
    input  logic              win_adv,
    output logic [ADDR_W-1:0] kx_nxt,
    output logic [ADDR_W-1:0] ky_nxt,
    output logic [ADDR_W-1:0] c_nxt,
    output logic [ADDR_W-1:0] ox_nxt,
    output logic [ADDR_W-1:0] oy_nxt,
    output logic [ADDR_W-1:0] win_idx,
    output logic              tap_last,
    output logic              all_last
);
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] K_M1  = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] CH_M1 = ADDR_W'(CH - 1);
    localparam logic [ADDR_W-1:0] OW_M1 = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] OH_M1 = ADDR_W'(OUT_H - 1);

    logic [ADDR_W-1:0] kx, ky, c, ox, oy, win_nxt;

    assign tap_last = (kx == K_M1) && (ky == K_M1) && (c == CH_M1);
    assign all_last = (ox == OW_M1) && (oy == OH_M1);

    // Next values are exported so the top can register addresses in step with the counters.
    always_comb begin
        kx_nxt  = kx;
        ky_nxt  = ky;
        c_nxt   = c;
        ox_nxt  = ox;
        oy_nxt  = oy;
        win_nxt = win_idx;
        if (clr) begin
            kx_nxt  = '0;
            ky_nxt  = '0;
            c_nxt   = '0;
            ox_nxt  = '0;
            oy_nxt  = '0;
            win_nxt = '0;
        end else if (tap_adv) begin
            kx_nxt = (kx == K_M1) ? '0 : kx + ONE;
            if (kx == K_M1) begin
                ky_nxt = (ky == K_M1) ? '0 : ky + ONE;
                if (ky == K_M1) begin
                    c_nxt = (c == CH_M1) ? '0 : c + ONE;
                end
            end
        end else if (win_adv) begin
            ox_nxt  = (ox == OW_M1) ? '0 : ox + ONE;
            win_nxt = win_idx + ONE;
            if (ox == OW_M1) begin
                oy_nxt = (oy == OH_M1) ? '0 : oy + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kx      <= '0;
            ky      <= '0;
            c       <= '0;
            ox      <= '0;
            oy      <= '0;
            win_idx <= '0;
        end else begin
            kx      <= kx_nxt;
            ky      <= ky_nxt;
            c       <= c_nxt;
            ox      <= ox_nxt;
            oy      <= oy_nxt;
            win_idx <= win_nxt;
        end
    end

endmodule

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - convolution window address generator: FSM, base registers, address adders
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int IMG_W     = 48,
    parameter int IMG_H     = 48,
    parameter int K         = 3,
    parameter int STRIDE    = 1,
    parameter int CH        = 1,
    parameter int CH_STRIDE = IMG_W * IMG_H
) (
    input  logic clk,
    input  logic rst_n,
    conv_addr_gen_if.master bus
);
    localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
    localparam int OUT_H = out_dim(IMG_H, K, STRIDE);

    localparam logic [ADDR_W-1:0] CHS = ADDR_W'(CH_STRIDE);
    localparam logic [ADDR_W-1:0] IW  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] STR = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] KK  = ADDR_W'(K * K);
    localparam logic [ADDR_W-1:0] KW  = ADDR_W'(K);

    state_t state, state_nxt;

    logic [ADDR_W-1:0] base_a_q, base_b_q, result_q;
    logic [ADDR_W-1:0] base_a_sel, base_b_sel;
    logic [ADDR_W-1:0] kx_n, ky_n, c_n, ox_n, oy_n, win_idx;
    logic [ADDR_W-1:0] addr_a_q, addr_b_q;
    logic              tap_last, all_last;
    logic              clr, tap_adv, win_adv;

    conv_win_counter #(
        .ADDR_W (ADDR_W),
        .K      (K),
        .CH     (CH),
        .OUT_W  (OUT_W),
        .OUT_H  (OUT_H)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .tap_adv  (tap_adv),
        .win_adv  (win_adv),
        .kx_nxt   (kx_n),
        .ky_nxt   (ky_n),
        .c_nxt    (c_n),
        .ox_nxt   (ox_n),
        .oy_nxt   (oy_n),
        .win_idx  (win_idx),
        .tap_last (tap_last),
        .all_last (all_last)
    );

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        tap_adv   = 1'b0;
        win_adv   = 1'b0;
        case (state)
            IDLE: begin
                clr = 1'b1;
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                if (!bus.stall) begin
                    tap_adv = 1'b1;
                    if (tap_last) state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (!bus.stall) begin
                    win_adv   = 1'b1;
                    state_nxt = all_last ? DONE : RUN;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The start edge uses the live inputs so the first pair is ready in the very next cycle.
    assign base_a_sel = (state == IDLE) ? bus.base_addr_a : base_a_q;
    assign base_b_sel = (state == IDLE) ? bus.base_addr_b : base_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base_a_q <= '0;
            base_b_q <= '0;
            result_q <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.start) begin
                base_a_q <= bus.base_addr_a;
                base_b_q <= bus.base_addr_b;
                result_q <= bus.result_addr;
            end
            addr_a_q <= base_a_sel + c_n * CHS + (oy_n * STR + ky_n) * IW + ox_n * STR + kx_n;
            addr_b_q <= base_b_sel + c_n * KK + ky_n * KW + kx_n;
        end
    end

    assign bus.addr_a     = addr_a_q;
    assign bus.addr_b     = addr_b_q;
    assign bus.addr_valid = (state == RUN) && !bus.stall;
    assign bus.win_last   = bus.addr_valid && tap_last;
    assign bus.wr_en      = (state == WRITE) && !bus.stall;
    assign bus.wr_addr    = result_q + win_idx;
    assign bus.busy       = (state == RUN) || (state == WRITE);
    assign bus.done       = (state == DONE);

endmodule
